// File: rtl/fg_prog_pkg.sv
// Shared types for the floating-gate program-verify sequencer.
// Command modes, completion status, FSM states and small sizing helpers.
package fg_prog_pkg;

  typedef enum logic [1:0] {
    MODE_READ   = 2'd0,
    MODE_INJECT = 2'd1,
    MODE_TUNNEL = 2'd2,
    MODE_RUN    = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    STAT_OK       = 2'd0,
    STAT_BUDGET   = 2'd1,
    STAT_BAD_ADDR = 2'd2
  } status_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_RECOVER,
    S_MEAS,
    S_CHECK,
    S_DONE
  } state_e;

  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/fg_indirect_prog_seq_if.sv
// Host command, mux-decoder drive and ADC readout bundle for the sequencer.
// slave = sequencer side, master = host/array/readout side.
interface fg_indirect_prog_seq_if
  import fg_prog_pkg::*;
#(
  parameter int ROWS   = 50,
  parameter int COLS   = 1,
  parameter int MEAS_W = 12,
  parameter int PW_W   = 16,
  parameter int NP_W   = 8
);
  localparam int RA_W = addr_w(ROWS);
  localparam int CA_W = addr_w(COLS);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_mode;
  logic [RA_W-1:0]   cmd_row;
  logic [CA_W-1:0]   cmd_col;
  logic [MEAS_W-1:0] cmd_target;
  logic [PW_W-1:0]   cmd_pw;
  logic [NP_W-1:0]   cmd_maxp;
  logic [RA_W-1:0]   row_addr;
  logic [CA_W-1:0]   col_addr;
  logic              drain_sel_en;
  logic              prog_mode;
  logic              vinj_en;
  logic              vtun_en;
  logic              meas_req;
  logic              meas_valid;
  logic [MEAS_W-1:0] meas_code;
  logic              done;
  logic [1:0]        status;
  logic [MEAS_W-1:0] last_meas;
  logic [NP_W-1:0]   pulses_used;

  modport slave (
    input  cmd_valid, cmd_mode, cmd_row, cmd_col, cmd_target, cmd_pw, cmd_maxp,
    input  meas_valid, meas_code,
    output cmd_ready, row_addr, col_addr, drain_sel_en, prog_mode, vinj_en, vtun_en,
    output meas_req, done, status, last_meas, pulses_used
  );

  modport master (
    output cmd_valid, cmd_mode, cmd_row, cmd_col, cmd_target, cmd_pw, cmd_maxp,
    output meas_valid, meas_code,
    input  cmd_ready, row_addr, col_addr, drain_sel_en, prog_mode, vinj_en, vtun_en,
    input  meas_req, done, status, last_meas, pulses_used
  );

endinterface

// File: rtl/fg_pulse_timer.sv
// Loadable down-counter: busy for exactly i_load cycles after i_start, o_expire on the last one.
// A new i_start overrides a running count so back-to-back intervals need no gap cycle.
module fg_pulse_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_start,
  input  logic [W-1:0] i_load,
  output logic         o_busy,
  output logic         o_expire
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_start) begin
      r_cnt <= i_load;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_busy   = (r_cnt != '0);
  assign o_expire = (r_cnt == W'(1));

endmodule

// File: rtl/fg_indirect_prog_seq.sv
// Program-verify sequencer: settle, pulse (inject/tunnel), recover, measure, compare against target.
// One command in flight; cmd_ready only in IDLE, meas wait unbounded, all outputs registered.
module fg_indirect_prog_seq
  import fg_prog_pkg::*;
#(
  parameter int ROWS   = 50,
  parameter int COLS   = 1,
  parameter int MEAS_W = 12,
  parameter int PW_W   = 16,
  parameter int NP_W   = 8,
  parameter int SETTLE = 8
) (
  input logic                   clk,
  input logic                   rst_n,
  fg_indirect_prog_seq_if.slave bus
);

  localparam int RA_W = addr_w(ROWS);
  localparam int CA_W = addr_w(COLS);
  localparam int TW   = max2(PW_W, $clog2(SETTLE + 1));
  localparam logic [TW-1:0] SETTLE_LD = TW'(max2(SETTLE, 1));

  state_e            r_state;
  mode_e             r_mode;
  logic [MEAS_W-1:0] r_target;
  logic [TW-1:0]     r_pw;
  logic [NP_W-1:0]   r_maxp;
  logic              r_cmd_ready;
  logic [RA_W-1:0]   r_row;
  logic [CA_W-1:0]   r_col;
  logic              r_drain;
  logic              r_prog;
  logic              r_vinj;
  logic              r_vtun;
  logic              r_meas_req;
  logic              r_done;
  status_e           r_status;
  logic [MEAS_W-1:0] r_last_meas;
  logic [NP_W-1:0]   r_pulses;

  mode_e         w_cmd_mode;
  logic          w_accept;
  logic          w_bad_addr;
  logic [TW-1:0] w_cmd_pw;
  logic          w_check_pass;
  logic          w_to_pulse;
  logic          w_tmr_start;
  logic [TW-1:0] w_tmr_load;
  logic          w_tmr_busy;
  logic          w_tmr_expire;

  assign w_cmd_mode = mode_e'(bus.cmd_mode);
  assign w_accept   = bus.cmd_valid & r_cmd_ready;
  // Tunnel and run act on whole-array lines, so only read/inject need a valid cell address.
  assign w_bad_addr = ((w_cmd_mode == MODE_READ) || (w_cmd_mode == MODE_INJECT)) &&
                      ((32'(bus.cmd_row) >= 32'(ROWS)) || (32'(bus.cmd_col) >= 32'(COLS)));
  assign w_cmd_pw   = (bus.cmd_pw == '0) ? TW'(1) : TW'(bus.cmd_pw);

  assign w_check_pass = (r_mode == MODE_READ) || (r_last_meas >= r_target);
  assign w_to_pulse   = (r_state == S_CHECK) && !w_check_pass && (r_pulses != r_maxp);

  always_comb begin
    w_tmr_start = 1'b0;
    w_tmr_load  = SETTLE_LD;
    case (r_state)
      S_IDLE:  w_tmr_start = w_accept && !w_bad_addr;
      S_SETUP: begin
        w_tmr_start = w_tmr_expire && (r_mode == MODE_TUNNEL);
        w_tmr_load  = r_pw;
      end
      S_CHECK: begin
        w_tmr_start = w_to_pulse;
        w_tmr_load  = r_pw;
      end
      S_PULSE: w_tmr_start = w_tmr_expire;
      default: w_tmr_start = 1'b0;
    endcase
  end

  fg_pulse_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  (w_tmr_start),
    .i_load   (w_tmr_load),
    .o_busy   (w_tmr_busy),
    .o_expire (w_tmr_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_mode      <= MODE_READ;
      r_target    <= '0;
      r_pw        <= '0;
      r_maxp      <= '0;
      r_cmd_ready <= 1'b0;
      r_row       <= '0;
      r_col       <= '0;
      r_drain     <= 1'b0;
      r_prog      <= 1'b0;
      r_vinj      <= 1'b0;
      r_vtun      <= 1'b0;
      r_meas_req  <= 1'b0;
      r_done      <= 1'b0;
      r_status    <= STAT_OK;
      r_last_meas <= '0;
      r_pulses    <= '0;
    end else begin
      r_done     <= 1'b0;
      r_meas_req <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cmd_ready <= 1'b1;
          if (w_accept) begin
            r_cmd_ready <= 1'b0;
            r_mode      <= w_cmd_mode;
            r_target    <= bus.cmd_target;
            r_pw        <= w_cmd_pw;
            r_maxp      <= bus.cmd_maxp;
            r_pulses    <= '0;
            if (w_bad_addr) begin
              r_status <= STAT_BAD_ADDR;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_status <= STAT_OK;
              r_row    <= bus.cmd_row;
              r_col    <= bus.cmd_col;
              r_prog   <= 1'b1;
              r_drain  <= (w_cmd_mode != MODE_TUNNEL);
              r_state  <= S_SETUP;
            end
          end
        end
        S_SETUP: begin
          if (w_tmr_expire) begin
            case (r_mode)
              MODE_TUNNEL: begin
                r_vtun  <= 1'b1;
                r_state <= S_PULSE;
              end
              MODE_RUN: begin
                r_prog  <= 1'b0;
                r_drain <= 1'b0;
                r_done  <= 1'b1;
                r_state <= S_DONE;
              end
              default: begin
                r_meas_req <= 1'b1;
                r_state    <= S_MEAS;
              end
            endcase
          end
        end
        S_PULSE: begin
          if (w_tmr_expire) begin
            r_vinj  <= 1'b0;
            r_vtun  <= 1'b0;
            if (r_pulses != r_maxp) r_pulses <= r_pulses + NP_W'(1);
            r_state <= S_RECOVER;
          end
        end
        S_RECOVER: begin
          if (w_tmr_expire) begin
            if (r_mode == MODE_TUNNEL) begin
              r_prog  <= 1'b0;
              r_drain <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_meas_req <= 1'b1;
              r_state    <= S_MEAS;
            end
          end
        end
        S_MEAS: begin
          if (bus.meas_valid) begin
            r_last_meas <= bus.meas_code;
            r_state     <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (w_to_pulse) begin
            r_vinj  <= 1'b1;
            r_state <= S_PULSE;
          end else begin
            r_status <= w_check_pass ? STAT_OK : STAT_BUDGET;
            r_prog   <= 1'b0;
            r_drain  <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          r_cmd_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  a_pulse_excl: assert property (@(posedge clk) disable iff (!rst_n) !(r_vinj && r_vtun));
  a_pulse_timed: assert property (@(posedge clk) disable iff (!rst_n)
    (r_vinj || r_vtun) |-> (w_tmr_busy && (r_state == S_PULSE)));

  assign bus.cmd_ready    = r_cmd_ready;
  assign bus.row_addr     = r_row;
  assign bus.col_addr     = r_col;
  assign bus.drain_sel_en = r_drain;
  assign bus.prog_mode    = r_prog;
  assign bus.vinj_en      = r_vinj;
  assign bus.vtun_en      = r_vtun;
  assign bus.meas_req     = r_meas_req;
  assign bus.done         = r_done;
  assign bus.status       = r_status;
  assign bus.last_meas    = r_last_meas;
  assign bus.pulses_used  = r_pulses;

endmodule

// File: doc/fg_indirect_prog_seq.md
Name: fg_indirect_prog_seq

Overview:
- Digital program-verify sequencer for indirect-programmed floating-gate arrays: the 4x2 indirect cell tiles behind the VinjDecode, drain-select and FourTgate prog-switch muxes.
- Parametrised successor to the fixed 50x1 island: any row/column count, selectable injection/tunnel/read modes, and a closed-loop inject-measure-compare loop with a pulse budget.
- Sits between the host command interface and the programming-mux decoders; receives measurements from an external ADC/readout.

Parameters:
- ROWS, 50, array rows (drain-select lines).
- COLS, 1, array columns (gate lines).
- RA_W, $clog2(ROWS) min 1, row address width.
- CA_W, $clog2(COLS) min 1, column address width.
- MEAS_W, 12, measurement/target code width.
- PW_W, 16, pulse-width counter width.
- NP_W, 8, pulse-count width.
- SETTLE, 8, switch-settle cycles before any pulse or measure.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  sequencer accepts command (high only in IDLE).
- cmd_mode  in  2  0=READ, 1=INJECT_VERIFY, 2=TUNNEL, 3=RUN.
- cmd_row  in  RA_W  target row.
- cmd_col  in  CA_W  target column.
- cmd_target  in  MEAS_W  verify target code.
- cmd_pw  in  PW_W  pulse width in cycles (0 treated as 1).
- cmd_maxp  in  NP_W  pulse budget (0 = one measure, no pulse).
- row_addr  out  RA_W  to vertical decoder.
- col_addr  out  CA_W  to horizontal decoder.
- drain_sel_en  out  1  enable selected drain line.
- prog_mode  out  1  1=prog switches in program position, 0=run.
- vinj_en  out  1  injection pulse gate.
- vtun_en  out  1  tunnel pulse gate.
- meas_req  out  1  request one ADC conversion.
- meas_valid  in  1  conversion result strobe.
- meas_code  in  MEAS_W  conversion result.
- done  out  1  one-cycle completion pulse.
- status  out  2  0=OK, 1=BUDGET_EXHAUSTED, 2=BAD_ADDR; held until next accept.
- last_meas  out  MEAS_W  most recent meas_code.
- pulses_used  out  NP_W  pulses applied in last command.

Behaviour:
- Reset: all outputs 0; state IDLE; prog_mode=0 (array in run configuration). Reset mid-pulse drops vinj_en/vtun_en in the same instant (asynchronous).
- Command accept is cmd_valid & cmd_ready. Fields are latched on accept; status and pulses_used clear on accept.
- Address check at accept: cmd_row>=ROWS or cmd_col>=COLS -> DONE with status=2, no switch activity. TUNNEL and RUN skip this check.
- States:
  - IDLE -> SETUP on accept.
  - SETUP: drive row_addr, col_addr, prog_mode=1 and drain_sel_en=1 (drain_sel_en=0 for TUNNEL) for SETTLE cycles. Then: READ -> MEAS; INJECT_VERIFY -> MEAS (pre-verify); TUNNEL -> PULSE; RUN -> DONE with prog_mode=0.
  - PULSE: vinj_en (INJECT) or vtun_en (TUNNEL) high for exactly max(cmd_pw,1) cycles; pulses_used increments on exit. Then RECOVER.
  - RECOVER: SETTLE cycles with both pulse enables low. TUNNEL -> DONE; INJECT -> MEAS.
  - MEAS: meas_req high for 1 cycle on entry, then wait for meas_valid. last_meas is captured on meas_valid. -> CHECK.
  - CHECK, 1 cycle:
    - READ -> DONE, status 0.
    - meas_code >= target (unsigned) -> DONE, status 0.
    - else if pulses_used == cmd_maxp -> DONE, status 1.
    - else -> PULSE.
  - DONE: done=1 for one cycle. prog_mode returns to 0 and drain_sel_en to 0, except after RUN where both remain 0. -> IDLE.
- meas_valid outside MEAS is ignored. meas_valid in the same cycle as meas_req is accepted.
- vinj_en and vtun_en are never high simultaneously. Neither is ever high outside PULSE.
- cmd_valid while busy: cmd_ready=0, command held off. No queueing.
- pulses_used saturates at cmd_maxp; no wrap.

Decomposition:
- Shared package fg_prog_pkg: mode enum (READ/INJECT_VERIFY/TUNNEL/RUN), status enum, state enum.
- One sub-module, fg_pulse_timer: loadable down-counter of width max(PW_W, $clog2(SETTLE+1)) with start/busy/expire. Reused for SETTLE, pulse and recover timing.

Test Plan:
- READ row 3 col 0, meas_code=0x200 after 5 cycles -> done with status 0, last_meas=0x200, pulses_used=0, vinj_en never high.
- INJECT_VERIFY target 0x300, maxp 10, pw 4; model returns 0x100 +0x80 per pulse -> exactly 4 pulses each 4 cycles wide, done with status 0, pulses_used=4.
- INJECT_VERIFY target 0xFFF, maxp 3 -> 3 pulses, done with status 1, last_meas = third post-pulse reading.
- Row=ROWS (50) -> done within 2 cycles, status 2, drain_sel_en/prog_mode never asserted.
- TUNNEL pw 0 -> vtun_en high exactly 1 cycle, drain_sel_en 0 throughout, done status 0.
- rst_n low mid-PULSE -> vinj_en falls immediately; after release, IDLE with cmd_ready=1 and all outputs 0.
